// File: rtl/swu_pkg.sv
// Shared constants and FSM encoding for the SWU coefficient ROM path.
package swu_pkg;

    localparam int unsigned SWU_ADDR_W    = 5;
    localparam int unsigned SWU_DATA_W    = 32;
    localparam int unsigned SWU_ROM_DEPTH = 29;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_FETCH = FETCH,
        ST_DRAIN = DRAIN
    } swu_state_e;

endpackage

// File: rtl/swu_skid_fifo.sv
// Two-entry output buffer that decouples the ROM read pipeline from consumer backpressure.
module swu_skid_fifo #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_idx;
    logic             r_wr_idx;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (r_count != 2'd0);
    // A full buffer can still accept a word when the head leaves in the same cycle.
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_idx <= 1'b0;
            r_wr_idx <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_rd_idx <= 1'b0;
            r_wr_idx <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_idx] <= wdata;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign rdata = r_mem[r_rd_idx];
    assign count = r_count;

endmodule

// File: rtl/swu_rom_reader.sv
// Sequences one full read of the registered-output SWU ROM per start and streams the words
// over valid/ready, hiding the one-cycle ROM latency behind a two-entry buffer.
module swu_rom_reader
    import swu_pkg::*;
#(
    parameter int unsigned DEPTH  = SWU_ROM_DEPTH,
    parameter int unsigned ADDR_W = SWU_ADDR_W,
    parameter int unsigned DATA_W = SWU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    // One extra pointer bit so a DEPTH of 2^ADDR_W never wraps within a run.
    localparam int unsigned    PTR_W    = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    swu_state_e        r_state;
    swu_state_e        w_state_next;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;
    logic              w_done_next;
    logic              w_accept;
    logic              w_pop;
    logic              w_issue;
    logic              w_is_last;
    logic              w_flush;
    logic [2:0]        w_occupancy;
    logic [1:0]        w_fifo_count;
    logic [DATA_W:0]   w_fifo_head;

    assign w_pop       = m_valid && m_ready;
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_is_last   = (r_rd_ptr == LAST_PTR);
    assign w_issue     = (r_state == ST_FETCH) && (w_occupancy < 3'd2);
    assign w_flush     = abort && (r_state != ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done_next  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_next = ST_FETCH;
                    w_accept     = 1'b1;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_issue && w_is_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_pop && w_fifo_head[DATA_W]) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_rd_ptr        <= '0;
            r_rom_addr      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= w_done_next;
            r_inflight <= w_issue && !abort;
            if (w_issue) begin
                r_inflight_last <= w_is_last;
            end
            if (w_accept) begin
                r_rd_ptr   <= '0;
                r_rom_addr <= '0;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                // The address parks on the last word instead of running past the image.
                if (!w_is_last) begin
                    r_rom_addr <= ADDR_W'(r_rd_ptr + 1'b1);
                end
            end
        end
    end

    swu_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_inflight),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata ({r_inflight_last, rom_data}),
        .rdata (w_fifo_head),
        .count (w_fifo_count)
    );

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign rom_en   = w_issue;
    assign rom_addr = r_rom_addr;
    assign m_valid  = (w_fifo_count != 2'd0);
    assign m_data   = w_fifo_head[DATA_W-1:0];
    assign m_last   = w_fifo_head[DATA_W];

endmodule
